// File: rtl/alu_p_register_stage_if.sv
// Bus between the SIMD ALU and its P register stage: ALU-side inputs and
// registered results/flags, grouped so the stage and its driver share one port.
interface alu_p_register_stage_if;
  logic        CEP;
  logic        RSTP;
  logic        in_valid;
  logic [1:0]  USE_SIMD;
  logic [31:0] S;
  logic [7:0]  alu_carry_out;
  logic        clr_sticky;
  logic [31:0] P;
  logic [7:0]  CARRYOUT;
  logic [7:0]  PATTERNDETECT;
  logic [7:0]  PATTERNBDETECT;
  logic [7:0]  OVERFLOW;
  logic [7:0]  UNDERFLOW;
  logic [7:0]  STICKY_OVF;
  logic        out_valid;

  // Driver side (ALU / testbench)
  modport master (
    output CEP, RSTP, in_valid, USE_SIMD, S, alu_carry_out, clr_sticky,
    input  P, CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW,
           STICKY_OVF, out_valid
  );

  // Register stage side
  modport slave (
    input  CEP, RSTP, in_valid, USE_SIMD, S, alu_carry_out, clr_sticky,
    output P, CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW,
           STICKY_OVF, out_valid
  );
endinterface

// File: rtl/alu_p_register_stage.sv
// P register stage after the 32-bit SIMD ALU: registers S into P, registers
// lane carries, and derives per-lane pattern detect, overflow/underflow and
// sticky overflow flags from S so they line up with P. One cycle latency.
module alu_p_register_stage #(
  parameter logic [31:0] PATTERN = 32'h0000_0000,
  parameter logic [31:0] MASK    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_p_register_stage_if.slave  bus
);

  // Reduce per-nibble results to per-lane results; each lane's value lands on
  // the bit of its top nibble, every other bit is 0.
  function automatic logic [7:0] lane_and(input logic [7:0] nib, input logic [1:0] mode);
    logic [7:0] r;
    r = '0;
    case (mode)
      2'b00: r[7] = &nib;
      2'b01: begin
        r[7] = &nib[7:4];
        r[3] = &nib[3:0];
      end
      2'b10: begin
        for (int k = 0; k < 4; k++) r[2*k+1] = nib[2*k+1] & nib[2*k];
      end
      default: r = nib;
    endcase
    return r;
  endfunction

  logic [31:0] r_p;
  logic [7:0]  r_carry;
  logic [7:0]  r_pd;
  logic [7:0]  r_pdb;
  logic [7:0]  r_ovf;
  logic [7:0]  r_unf;
  logic [7:0]  r_sticky;
  logic [1:0]  r_mode;
  logic        r_out_valid;

  logic [31:0] w_match_pd;
  logic [31:0] w_match_pdb;
  logic [7:0]  w_nib_pd;
  logic [7:0]  w_nib_pdb;
  logic [7:0]  w_pd;
  logic [7:0]  w_pdb;
  logic [7:0]  w_top;
  logic        w_mode_chg;
  logic [7:0]  w_pd_hist;
  logic [7:0]  w_pdb_hist;
  logic [7:0]  w_ovf_next;
  logic [7:0]  w_unf_next;
  logic        w_acc;

  // Per-bit match against PATTERN and ~PATTERN; masked bits always match
  assign w_match_pd  = ~((bus.S ^  PATTERN) & ~MASK);
  assign w_match_pdb = ~((bus.S ^ ~PATTERN) & ~MASK);

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign w_nib_pd[gi]  = &w_match_pd[4*gi +: 4];
    assign w_nib_pdb[gi] = &w_match_pdb[4*gi +: 4];
  end

  assign w_pd  = lane_and(w_nib_pd,  bus.USE_SIMD);
  assign w_pdb = lane_and(w_nib_pdb, bus.USE_SIMD);
  assign w_top = lane_and(8'hFF,     bus.USE_SIMD);

  // A lane reconfiguration invalidates the stored history, so it reads as 0
  assign w_mode_chg = (bus.USE_SIMD != r_mode);
  assign w_pd_hist  = w_mode_chg ? 8'h00 : r_pd;
  assign w_pdb_hist = w_mode_chg ? 8'h00 : r_pdb;

  // Left the pattern band: from PATTERN side is overflow, from ~PATTERN side underflow
  assign w_ovf_next = w_pd_hist  & ~w_pd & ~w_pdb;
  assign w_unf_next = w_pdb_hist & ~w_pd & ~w_pdb;

  assign w_acc = bus.CEP & bus.in_valid & ~bus.RSTP;

  // Main result/flag registers: RSTP clears, CEP qualifies, in_valid loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p         <= '0;
      r_carry     <= '0;
      r_pd        <= '0;
      r_pdb       <= '0;
      r_ovf       <= '0;
      r_unf       <= '0;
      r_mode      <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.RSTP) begin
      r_p         <= '0;
      r_carry     <= '0;
      r_pd        <= '0;
      r_pdb       <= '0;
      r_ovf       <= '0;
      r_unf       <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.CEP) begin
      if (bus.in_valid) begin
        r_p         <= bus.S;
        r_carry     <= bus.alu_carry_out & w_top;
        r_pd        <= w_pd;
        r_pdb       <= w_pdb;
        r_ovf       <= w_ovf_next;
        r_unf       <= w_unf_next;
        r_mode      <= bus.USE_SIMD;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Sticky flags: clear beats a simultaneous new flag; RSTP leaves them alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
    end else if (bus.clr_sticky) begin
      r_sticky <= '0;
    end else if (w_acc) begin
      r_sticky <= r_sticky | w_ovf_next | w_unf_next;
    end
  end

  assign bus.P              = r_p;
  assign bus.CARRYOUT       = r_carry;
  assign bus.PATTERNDETECT  = r_pd;
  assign bus.PATTERNBDETECT = r_pdb;
  assign bus.OVERFLOW       = r_ovf;
  assign bus.UNDERFLOW      = r_unf;
  assign bus.STICKY_OVF     = r_sticky;
  assign bus.out_valid      = r_out_valid;

endmodule
